// File: rtl/jt12_reg_upd.sv
// jt12_reg_upd: operator register write feeder and 24-slot counter; optional one-entry write queue via JT12_UPD_QUEUE_EN
module jt12_reg_upd #(
  parameter int OFS_I  = 0,
  parameter int OFS_II = 0,
  parameter int OFS_IV = 0
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       clk_en,
  input  logic       write,
  input  logic       part,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       up_tl,
  output logic       up_dt1,
  output logic       up_ks_ar,
  output logic       up_amen_dr,
  output logic       up_sr,
  output logic       up_sl_rr,
  output logic       up_ssgeg,
  output logic       update_op_I,
  output logic       update_op_II,
  output logic       update_op_IV,
  output logic [2:0] cur_ch,
  output logic [1:0] cur_op,
  output logic       busy,
  output logic       wr_lost
);
  logic [3:0] typ, w_typ;
  logic [4:0] tgt, w_tgt, slot, rev;
  logic       w_valid, clearing;
`ifdef JT12_UPD_QUEUE_EN
  logic [3:0] q_typ;
  logic [4:0] q_tgt;
  logic [7:0] q_din;
  logic       q_full;
`endif
  function automatic logic [4:0] wrap24(input logic [5:0] t);
    return t >= 6'd24 ? 5'(t - 6'd24) : t[4:0];
  endfunction
  assign w_typ    = addr[7:4];
  assign w_valid  = write && addr[1:0] != 2'd3 && w_typ >= 4'd3 && w_typ <= 4'd9;
  assign w_tgt    = 5'({addr[2], addr[3]}) * 5'd6 + 5'(part) * 5'd3 + 5'(addr[1:0]);
  assign slot     = 5'(cur_op) * 5'd6 + 5'(cur_ch);
  assign clearing = busy && clk_en && rev == 5'd23;
  assign up_dt1     = busy && typ == 4'd3;
  assign up_tl      = busy && typ == 4'd4;
  assign up_ks_ar   = busy && typ == 4'd5;
  assign up_amen_dr = busy && typ == 4'd6;
  assign up_sr      = busy && typ == 4'd7;
  assign up_sl_rr   = busy && typ == 4'd8;
  assign up_ssgeg   = busy && typ == 4'd9;
  assign update_op_I  = busy && slot == wrap24(6'(tgt) + 6'(OFS_I));
  assign update_op_II = busy && slot == wrap24(6'(tgt) + 6'(OFS_II));
  assign update_op_IV = busy && slot == wrap24(6'(tgt) + 6'(OFS_IV));
  // slot counter, revolution count and write acceptance; later assignments override earlier ones
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur_ch  <= '0;
      cur_op  <= '0;
      rev     <= '0;
      busy    <= 1'b0;
      typ     <= '0;
      tgt     <= '0;
      dout    <= '0;
      wr_lost <= 1'b0;
`ifdef JT12_UPD_QUEUE_EN
      q_typ   <= '0;
      q_tgt   <= '0;
      q_din   <= '0;
      q_full  <= 1'b0;
`endif
    end else begin
      if (clk_en) begin
        cur_ch <= cur_ch == 3'd5 ? 3'd0 : cur_ch + 3'd1;
        if (cur_ch == 3'd5) cur_op <= cur_op + 2'd1;
        if (busy) rev <= rev + 5'd1;
        if (clearing) busy <= 1'b0;
      end
`ifdef JT12_UPD_QUEUE_EN
      if (clearing && q_full) begin
        typ    <= q_typ;
        tgt    <= q_tgt;
        dout   <= q_din;
        busy   <= 1'b1;
        rev    <= '0;
        q_full <= 1'b0;
        if (w_valid) wr_lost <= 1'b1;
      end else if (w_valid && (!busy || clearing)) begin
        typ  <= w_typ;
        tgt  <= w_tgt;
        dout <= din;
        busy <= 1'b1;
        rev  <= '0;
      end else if (w_valid && !q_full) begin
        q_typ  <= w_typ;
        q_tgt  <= w_tgt;
        q_din  <= din;
        q_full <= 1'b1;
      end else if (w_valid) wr_lost <= 1'b1;
`else
      if (w_valid && (!busy || clearing)) begin
        typ  <= w_typ;
        tgt  <= w_tgt;
        dout <= din;
        busy <= 1'b1;
        rev  <= '0;
      end else if (w_valid) wr_lost <= 1'b1;
`endif
    end
endmodule
